spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param.sv | 200 ++++++++++++++++++++
 tb/tb_spi_master_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parameterised SPI master, one word per start, optional held chip-select
// Optional feature: define SPIM_LOOPBACK_EN to add the loopback input (receive path samples internal mosi).
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SPIM_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    input  logic              cont,
    input  logic [15:0]       div_factor,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              avail
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    localparam int            EW        = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d, h_q, h_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, cont_q, cont_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, avail_q, avail_d;

    logic              h_end, rx_bit, ld_lsb, ld_cpha, leading, do_sample, do_drive;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

`ifdef SPIM_LOOPBACK_EN
    assign rx_bit = loopback ? mosi_q : miso;
`else
    assign rx_bit = miso;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_d        = h_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        sel_d      = sel_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        cont_d     = cont_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        avail_d    = 1'b0;

        h_end     = (cnt_q == h_q - 16'd1);
        leading   = ~edge_q[0];
        do_sample = cpha_q ? ~leading : leading;
        do_drive  = cpha_q ? leading : (~leading && (edge_q != LAST_EDGE));

        // A start from HOLD keeps the held slave, mode and bit order
        ld_lsb  = (state_q == IDLE) ? lsb_first : lsb_q;
        ld_cpha = (state_q == IDLE) ? mode[0]   : cpha_q;

        if ((state_q == SETUP) || (state_q == XFER) || (state_q == DONE)) begin
            cnt_d = h_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    if (state_q == IDLE) begin
                        sel_d  = cs_sel;
                        cpol_d = mode[1];
                        cpha_d = mode[0];
                        lsb_d  = lsb_first;
                        sclk_d = mode[1];
                    end
                    h_d    = (div_factor == 16'd0) ? 16'd1 : div_factor;
                    cont_d = cont;
                    cnt_d  = 16'd0;
                    edge_d = '0;
                    rx_d   = '0;
                    // CPHA=0 presents the first bit before the first clock edge
                    if (!ld_cpha) begin
                        mosi_d = head_bit(data_in, ld_lsb);
                        tx_d   = shift_word(data_in, ld_lsb);
                    end else begin
                        tx_d   = data_in;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (h_end) state_d = XFER;
            end
            XFER: begin
                if (h_end) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EW'(1);
                    if (do_sample) begin
                        rx_d = lsb_q ? {rx_bit, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], rx_bit};
                    end
                    if (do_drive) begin
                        mosi_d = head_bit(tx_q, lsb_q);
                        tx_d   = shift_word(tx_q, lsb_q);
                    end
                    if (edge_q == LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (h_end) begin
                    data_out_d = rx_q;
                    avail_d    = 1'b1;
                    state_d    = cont_q ? HOLD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            h_q        <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            sel_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            cont_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            avail_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_q        <= h_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            sel_q      <= sel_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            cont_q     <= cont_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            avail_q    <= avail_d;
        end
    end

    // Out-of-range selects decode to no line, so the word runs with all cs_n high
    always_comb begin
        cs_n = '1;
        if (state_q != IDLE) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (sel_q == SEL_W'(i)) cs_n[i] = 1'b0;
            end
        end
    end

    assign busy     = (state_q == SETUP) || (state_q == XFER) || (state_q == DONE);
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign data_out = data_out_q;
    assign avail    = avail_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench for spi_master_param with a behavioural SPI slave
module tb_spi_master_param;

    logic        clk = 1'b0;
    logic        reset, start, lsb_first, cont, miso, loopback;
    logic [7:0]  data_in;
    logic [2:0]  cs_sel;
    logic [1:0]  mode;
    logic [15:0] div_factor;
    logic        mosi, sclk, busy, avail;
    logic [3:0]  cs_n;
    logic [7:0]  data_out;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(8), .NUM_CS(4), .SEL_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SPIM_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .start      (start),
        .data_in    (data_in),
        .cs_sel     (cs_sel),
        .mode       (mode),
        .lsb_first  (lsb_first),
        .cont       (cont),
        .div_factor (div_factor),
        .miso       (miso),
        .mosi       (mosi),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .data_out   (data_out),
        .busy       (busy),
        .avail      (avail)
    );

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   avail_cnt = 0;

    logic [1:0] cur_mode = 2'b00;
    logic       cur_lsb = 1'b0;
    int         cur_sel = 0;
    logic [7:0] slave_word = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic sbit(input int i);
        if (i > 7) return 1'b0;
        return cur_lsb ? slave_word[i] : slave_word[7-i];
    endfunction

    function automatic logic [3:0] cs_exp(input int s);
        return (s < 4) ? ~(4'b0001 << s) : 4'hF;
    endfunction

    // Slave model plus scoreboard consumer, sampled on the falling edge
    initial begin
        int   busy_cnt = 0;
        int   s_idx = 0;
        logic [7:0] s_word = 8'h00;
        logic prev_busy = 1'b0, prev_sclk = 1'b0, prev_avail = 1'b0;
        exp_t e;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (busy && !prev_busy) begin
                    busy_cnt = 1;
                    s_idx    = 0;
                    s_word   = 8'h00;
                    if (!cur_mode[0]) miso = sbit(0);
                end else if (busy) begin
                    busy_cnt++;
                    if (sclk !== prev_sclk) begin
                        if (sclk !== cur_mode[1]) begin
                            if (cur_mode[0]) miso = sbit(s_idx);
                            else s_word = cur_lsb ? {mosi, s_word[7:1]} : {s_word[6:0], mosi};
                        end else begin
                            if (cur_mode[0]) s_word = cur_lsb ? {mosi, s_word[7:1]} : {s_word[6:0], mosi};
                            s_idx++;
                            if (!cur_mode[0]) miso = sbit(s_idx);
                        end
                    end
                end
                if (prev_avail) check("avail_one_cycle", avail, 0);
                if (avail) begin
                    avail_cnt++;
                    check("avail_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("data_out", data_out, e.rx);
                        check("mosi_word", s_word, e.tx);
                        check("busy_cycles", busy_cnt, e.cyc);
                        check("busy_low_at_avail", busy, 0);
                    end
                end
            end
            prev_busy  = busy;
            prev_sclk  = sclk;
            prev_avail = avail;
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] sw, input logic [1:0] md,
                        input logic lsb, input logic [15:0] div, input int sel, input logic cn,
                        input bit from_hold, input bit lb, input bit mid_start);
        exp_t e;
        int   h, n, c0;
        @(negedge clk);
        if (!from_hold) begin
            cur_mode = md;
            cur_lsb  = lsb;
            cur_sel  = sel;
        end
        slave_word = sw;
        data_in    = d;
        mode       = md;
        lsb_first  = lsb;
        div_factor = div;
        cs_sel     = 3'(sel);
        cont       = cn;
        loopback   = lb;
        start      = 1'b1;
        h = (div == 16'd0) ? 1 : int'(div);
        e.rx = lb ? d : sw;
        e.tx = d;
        e.cyc = 18 * h;
        exp_q.push_back(e);
        c0 = avail_cnt;
        @(negedge clk);
        start = 1'b0;
        check("setup_busy", busy, 1);
        check("setup_sclk_cpol", sclk, cur_mode[1]);
        check("setup_cs_n", cs_n, cs_exp(cur_sel));
        if (!cur_mode[0]) check("setup_first_mosi", mosi, cur_lsb ? d[0] : d[7]);
        if (mid_start) begin
            repeat (h + 10) @(negedge clk);
            data_in = ~d;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
            data_in = d;
            check("xfer_cs_n", cs_n, cs_exp(cur_sel));
        end
        n = 0;
        while (avail_cnt == c0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("avail_seen", avail_cnt != c0, 1);
        check("end_cs_n", cs_n, cn ? cs_exp(cur_sel) : 4'hF);
        check("end_sclk_cpol", sclk, cur_mode[1]);
    endtask

    initial begin
        int c0;
        reset = 1'b1; start = 1'b0; data_in = 8'h00; cs_sel = 3'd0; mode = 2'b00;
        lsb_first = 1'b0; cont = 1'b0; div_factor = 16'd2; loopback = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_avail", avail, 0);
        reset = 1'b0;

        send(8'hA5, 8'h3C, 2'd0, 1'b0, 16'd2, 0, 1'b0, 0, 0, 0);
        for (int m = 1; m < 4; m++) send(8'h81, 8'h7E, 2'(m), 1'b0, 16'd3, 1, 1'b0, 0, 0, 0);
        send(8'h01, 8'hC3, 2'd0, 1'b1, 16'd0, 3, 1'b0, 0, 0, 0);

        send(8'h11, 8'h22, 2'd0, 1'b0, 16'd1, 2, 1'b1, 0, 0, 0);
        repeat (5) @(negedge clk);
        check("hold_cs_n", cs_n, 4'b1011);
        check("hold_busy", busy, 0);
        send(8'h33, 8'h44, 2'd3, 1'b1, 16'd2, 0, 1'b1, 1, 0, 0);
        repeat (3) @(negedge clk);
        check("hold2_cs_n", cs_n, 4'b1011);
        send(8'h55, 8'h66, 2'd1, 1'b1, 16'd1, 1, 1'b0, 1, 0, 0);

        send(8'hC6, 8'h9D, 2'd2, 1'b1, 16'd1, 5, 1'b0, 0, 0, 0);
        send(8'h5C, 8'hE1, 2'd0, 1'b0, 16'd2, 1, 1'b0, 0, 0, 1);

        // Abort mid-XFER with reset; start held alongside reset must lose
        @(negedge clk);
        cur_mode = 2'd0; cur_lsb = 1'b0; cur_sel = 1;
        data_in = 8'hF0; mode = 2'd0; lsb_first = 1'b0; div_factor = 16'd2;
        cs_sel = 3'd1; cont = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = avail_cnt;
        repeat (12) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_cs_n", cs_n, 4'hF);
        check("abort_busy", busy, 0);
        check("abort_avail", avail, 0);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_data_out", data_out, 0);
        @(negedge clk);
        check("reset_wins_busy", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_avail", avail_cnt, c0);
        check("abort_idle_busy", busy, 0);

`ifdef SPIM_LOOPBACK_EN
        send(8'h5A, 8'hFF, 2'd0, 1'b0, 16'd2, 0, 1'b0, 0, 1, 0);
        send(8'h5A, 8'h00, 2'd3, 1'b1, 16'd1, 0, 1'b0, 0, 1, 0);
        loopback = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
